// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding and sizing helpers used by the top level and its callers.
// No logic of its own.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2)).
    // log10(2) ~= 0.30103, scaled to integer arithmetic so it is usable
    // in parameter expressions.
    function automatic int min_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

    // Width of a counter that must hold w-1.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble adjust cell: adds 3 to a BCD digit of 5 or more.
// Latency: combinational. Backpressure: none.
// Ports: din (4-bit digit in), dout (adjusted digit), bad (din is not a legal BCD code).
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       bad
);

    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
        bad  = (din >= 4'd10);
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one operand bit per clock).
// Latency: START accepted at edge N -> DONE high in cycle N+W+1; one conversion per W+2 cycles.
// Backpressure: START is only honoured while ready=1; requests while busy are dropped, not queued.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   start, binary  conversion request and operand (operand sampled on the accepted start only)
//   ready          idle, can accept start
//   done           one-cycle pulse; bcd/sign/overflow valid from this cycle and held until next done
//   bcd            packed BCD result, digit 0 in bits [3:0]
//   sign           operand was negative (SIGNED=1 only)
//   overflow       result needed more than DIGITS digits; bcd holds the low digits
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W      = 10,
    parameter int DIGITS = 4,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [W-1:0]          binary,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  sign,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = cnt_width(W);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    opnd;
    logic [BW-1:0]   work;
    logic [BW-1:0]   work_adj;
    logic [BW-1:0]   work_nx;
    logic [DIGITS-1:0] bad;
    logic            ovf;
    logic            ovf_nx;
    logic            sign_q;
    logic            neg;
    logic [W-1:0]    mag;

    // Magnitude of the operand. The negation is taken modulo 2^W and read
    // back as unsigned, so the most-negative value maps to 2^(W-1) cleanly.
    always_comb begin
        neg = (SIGNED != 0) && binary[W-1];
        mag = neg ? (~binary + W'(1)) : binary;
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (work[4*g +: 4]),
                .dout (work_adj[4*g +: 4]),
                .bad  (bad[g])
            );
        end
    endgenerate

    // The top adjusted digit's MSB is the bit about to fall off the register;
    // an adjusted top digit >= 8 is exactly that bit being set. A corrupt
    // (non-BCD) digit also marks the result as untrustworthy.
    always_comb begin
        work_nx = {work_adj[BW-2:0], opnd[W-1]};
        ovf_nx  = ovf | work_adj[BW-1] | (|bad);
    end

    always_comb begin
        state_nx = IDLE;
        ready    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                ready    = 1'b1;
                state_nx = start ? SHIFT : IDLE;
            end
            SHIFT: begin
                state_nx = (cnt == '0) ? DONE_ST : SHIFT;
            end
            DONE_ST: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            opnd     <= '0;
            work     <= '0;
            ovf      <= 1'b0;
            sign_q   <= 1'b0;
            bcd      <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd   <= mag;
                        sign_q <= neg;
                        work   <= '0;
                        ovf    <= 1'b0;
                        cnt    <= CW'(W - 1);
                    end
                end
                SHIFT: begin
                    work <= work_nx;
                    opnd <= {opnd[W-2:0], 1'b0};
                    ovf  <= ovf_nx;
                    cnt  <= cnt - 1'b1;
                    // Publish on the final shift so the result is already
                    // on the outputs during the DONE_ST cycle.
                    if (cnt == '0) begin
                        bcd      <= work_nx;
                        overflow <= ovf_nx;
                        sign     <= sign_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
